// File: rtl/life_grid_engine.sv
// life_grid_engine: row-serial Game of Life engine over an H x W register grid.
// A generation is computed in place, one row per clock, over H clocks.
// Registered read port for the renderer, row write port for pattern loads.
// Optional build macro: LIFE_POPCOUNT_EN adds the population and extinct outputs.
`timescale 1ns/1ps
module life_grid_engine #(
    parameter int         W       = 16,
    parameter int         H       = 16,
    parameter logic [8:0] BIRTH   = 9'b000001000,
    parameter logic [8:0] SURVIVE = 9'b000001100,
    parameter bit         WRAP    = 1'b1,
    parameter int         GW      = 16,
    localparam int        RA      = $clog2(H)
`ifdef LIFE_POPCOUNT_EN
    ,
    localparam int        PW      = $clog2(W*H+1)
`endif
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          gen_tick,
    input  logic          run,
    input  logic          step,
    input  logic          load_en,
    input  logic [RA-1:0] load_row,
    input  logic [W-1:0]  load_data,
    input  logic          clear,
    input  logic [RA-1:0] rd_row,
    output logic [W-1:0]  rd_data,
    output logic          busy,
    output logic          done,
    output logic [GW-1:0] gen_count,
`ifdef LIFE_POPCOUNT_EN
    output logic [PW-1:0] population,
    output logic          extinct,
`endif
    output logic          overrun
);

    typedef enum logic {S_IDLE, S_COMPUTE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_grid [H];
    logic [RA-1:0] r_row;
    logic [W-1:0]  r_row0_orig;   // pre-generation copy of row 0 (row H-1's lower neighbour)
    logic [W-1:0]  r_prev_orig;   // pre-generation copy of the row just overwritten
    logic [W-1:0]  r_rd_data;
    logic          r_busy;
    logic          r_done;
    logic          r_overrun;
    logic [GW-1:0] r_gen_count;

    logic          w_start;
    logic          w_last_row;
    logic          w_load_ok;
    logic          w_rd_ok;
    logic [RA-1:0] w_below_idx;
    logic [W-1:0]  w_above, w_cur, w_below, w_next;
    logic [W-1:0]  w_al, w_ar, w_cl, w_cr, w_bl, w_br;
    logic [3:0]    w_cnt [W];

    // Neighbour at column c-1 presented at bit c (column -1 wraps or reads dead).
    function automatic logic [W-1:0] from_left(input logic [W-1:0] v);
        return {v[W-2:0], (WRAP ? v[W-1] : 1'b0)};
    endfunction

    // Neighbour at column c+1 presented at bit c (column W wraps or reads dead).
    function automatic logic [W-1:0] from_right(input logic [W-1:0] v);
        return {(WRAP ? v[0] : 1'b0), v[W-1:1]};
    endfunction

`ifdef LIFE_POPCOUNT_EN
    logic [PW-1:0] r_pop_acc;
    logic [PW-1:0] r_population;
    logic          r_extinct;
    logic [PW-1:0] w_row_pop;
    logic [PW-1:0] w_pop_sum;

    // Live cells in the row being written this cycle, added to the running total.
    always_comb begin
        w_row_pop = '0;
        for (int c = 0; c < W; c++) begin
            w_row_pop = w_row_pop + PW'(w_next[c]);
        end
        w_pop_sum = r_pop_acc + w_row_pop;
    end

    // An extinct grid stops free-running generations; a manual step still works.
    assign w_start = step | (run & gen_tick & ~r_extinct);
`else
    assign w_start = step | (run & gen_tick);
`endif

    assign w_last_row  = (r_row == RA'(H - 1));
    assign w_below_idx = w_last_row ? '0 : (r_row + RA'(1));
    assign w_load_ok   = (int'(load_row) < H);
    assign w_rd_ok     = (int'(rd_row) < H);

    // Three-row window plus rule lookup for the row currently being computed.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        w_next = '0;
        w_cnt  = '{default: '0};
        w_cur  = r_grid[r_row];
        if (r_row == '0) begin
            w_above = WRAP ? r_grid[H-1] : '0;
        end else begin
            w_above = r_prev_orig;
        end
        if (w_last_row) begin
            w_below = WRAP ? r_row0_orig : '0;
        end else begin
            w_below = r_grid[w_below_idx];
        end
        w_al = from_left(w_above);
        w_ar = from_right(w_above);
        w_cl = from_left(w_cur);
        w_cr = from_right(w_cur);
        w_bl = from_left(w_below);
        w_br = from_right(w_below);
        for (int c = 0; c < W; c++) begin
            w_cnt[c]  = 4'(w_al[c]) + 4'(w_above[c]) + 4'(w_ar[c])
                      + 4'(w_cl[c]) + 4'(w_cr[c])
                      + 4'(w_bl[c]) + 4'(w_below[c]) + 4'(w_br[c]);
            w_next[c] = w_cur[c] ? SURVIVE[w_cnt[c]] : BIRTH[w_cnt[c]];
        end
    end

    // Control FSM and grid update: loads/clear in IDLE, one row per clock in COMPUTE.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the grid is a register array that must power up empty, so it
            // sits on the async reset like any other state (it is not a RAM).
            for (int i = 0; i < H; i++) begin
                r_grid[i] <= '0;
            end
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_row0_orig <= '0;
            r_prev_orig <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_gen_count <= '0;
`ifdef LIFE_POPCOUNT_EN
            r_pop_acc    <= '0;
            r_population <= '0;
            r_extinct    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the pre-edge value regardless of statement order.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < H; i++) begin
                            r_grid[i] <= '0;
                        end
                        r_overrun <= 1'b0;
                    end else if (load_en && w_load_ok) begin
                        r_grid[load_row] <= load_data;
                    end
                    if (w_start) begin
                        r_state <= S_COMPUTE;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        // Capture row 0 as it will be after this cycle's clear/load.
                        if (clear) begin
                            r_row0_orig <= '0;
                        end else if (load_en && load_row == '0) begin
                            r_row0_orig <= load_data;
                        end else begin
                            r_row0_orig <= r_grid[0];
                        end
`ifdef LIFE_POPCOUNT_EN
                        r_pop_acc <= '0;
`endif
                    end
                end
                S_COMPUTE: begin
                    if (w_start) begin
                        r_overrun <= 1'b1;
                    end
                    r_grid[r_row] <= w_next;
                    r_prev_orig   <= w_cur;
`ifdef LIFE_POPCOUNT_EN
                    r_pop_acc <= w_pop_sum;
`endif
                    if (w_last_row) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_gen_count <= r_gen_count + GW'(1);
                        r_row       <= '0;
`ifdef LIFE_POPCOUNT_EN
                        r_population <= w_pop_sum;
                        r_extinct    <= (w_pop_sum == '0);
`endif
                    end else begin
                        r_row <= r_row + RA'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port, live every cycle including mid-generation.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_ok ? r_grid[rd_row] : '0;
        end
    end

    assign rd_data   = r_rd_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign gen_count = r_gen_count;
    assign overrun   = r_overrun;
`ifdef LIFE_POPCOUNT_EN
    assign population = r_population;
    assign extinct    = r_extinct;
`endif

endmodule

// File: tb/tb_life_grid_engine.sv
// tb_life_grid_engine: directed scoreboard bench for life_grid_engine.
// A toroidal instance is the main DUT; a dead-boundary twin shares its inputs.
// Expected done/gen_count and read-port values are queued when stimulus is
// issued and compared by a separate monitor when the DUT presents them.
// Build macro LIFE_POPCOUNT_EN enables the population/extinct checks.
`timescale 1ns/1ps
module tb_life_grid_engine;

    localparam int W  = 16;
    localparam int H  = 16;
    localparam int RA = 4;
    localparam int GW = 16;
`ifdef LIFE_POPCOUNT_EN
    localparam int PW = $clog2(W*H+1);
`endif

    logic          clk_in    = 1'b0;
    logic          rst_n     = 1'b0;
    logic          gen_tick  = 1'b0;
    logic          run       = 1'b0;
    logic          step      = 1'b0;
    logic          load_en   = 1'b0;
    logic [RA-1:0] load_row  = '0;
    logic [W-1:0]  load_data = '0;
    logic          clear     = 1'b0;
    logic [RA-1:0] rd_row    = '0;

    logic [W-1:0]  rd_data, rd_data_d;
    logic          busy, busy_d, done, done_d, overrun, overrun_d;
    logic [GW-1:0] gen_count, gen_count_d;
`ifdef LIFE_POPCOUNT_EN
    logic [PW-1:0] population, population_d;
    logic          extinct, extinct_d;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_gen  = 0;

    typedef struct {
        int    gen;
        int    pop;
        string tag;
    } done_exp_t;

    typedef struct {
        bit           dead;
        int           row;
        logic [W-1:0] val;
        string        tag;
    } rd_exp_t;

    done_exp_t done_q[$];
    rd_exp_t   rd_q[$];
    logic      rd_req   = 1'b0;
    logic      rd_req_p = 1'b0;

    life_grid_engine #(.W(W), .H(H), .WRAP(1'b1), .GW(GW)) u_dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .gen_tick  (gen_tick),
        .run       (run),
        .step      (step),
        .load_en   (load_en),
        .load_row  (load_row),
        .load_data (load_data),
        .clear     (clear),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .gen_count (gen_count),
`ifdef LIFE_POPCOUNT_EN
        .population(population),
        .extinct   (extinct),
`endif
        .overrun   (overrun)
    );

    life_grid_engine #(.W(W), .H(H), .WRAP(1'b0), .GW(GW)) u_dut_dead (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .gen_tick  (gen_tick),
        .run       (run),
        .step      (step),
        .load_en   (load_en),
        .load_row  (load_row),
        .load_data (load_data),
        .clear     (clear),
        .rd_row    (rd_row),
        .rd_data   (rd_data_d),
        .busy      (busy_d),
        .done      (done_d),
        .gen_count (gen_count_d),
`ifdef LIFE_POPCOUNT_EN
        .population(population_d),
        .extinct   (extinct_d),
`endif
        .overrun   (overrun_d)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push_done(input int g, input int p, input string tag);
        done_q.push_back('{gen: g, pop: p, tag: tag});
    endfunction

    // Bench-side pipeline matching the one-cycle read latency.
    always @(posedge clk_in) rd_req_p <= rd_req;

    // Monitor: pops the scoreboard whenever the DUT presents a done or read data.
    initial begin
        done_exp_t de;
        rd_exp_t   re;
        forever begin
            @(negedge clk_in);
            if (done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 gen_count=%0d expected no done", gen_count);
                end else begin
                    de = done_q.pop_front();
                    check({de.tag, "_gen_count"}, 32'(gen_count), de.gen);
`ifdef LIFE_POPCOUNT_EN
                    check({de.tag, "_population"}, 32'(population), de.pop);
`endif
                end
            end
            if (rd_req_p) begin
                if (rd_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_scoreboard_empty: got read with no expectation");
                end else begin
                    re = rd_q.pop_front();
                    check($sformatf("%s_%s_row%0d", re.tag, re.dead ? "dead" : "wrap", re.row),
                          32'(re.dead ? rd_data_d : rd_data), 32'(re.val));
                end
            end
        end
    end

    // All stimulus helpers start and end on a falling edge.
    // NOTE: the bench drives inputs with blocking assignments at the falling edge,
    // half a cycle away from the edge where the DUT samples them.
    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic read_row(input bit dead, input int row, input logic [W-1:0] val, input string tag);
        rd_row = row[RA-1:0];
        rd_req = 1'b1;
        rd_q.push_back('{dead: dead, row: row, val: val, tag: tag});
        @(negedge clk_in);
        rd_req = 1'b0;
    endtask

    task automatic load(input int row, input logic [W-1:0] data);
        load_en   = 1'b1;
        load_row  = row[RA-1:0];
        load_data = data;
        @(negedge clk_in);
        load_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk_in);
        clear = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk_in);
        step = 1'b0;
    endtask

    task automatic pulse_tick();
        gen_tick = 1'b1;
        @(negedge clk_in);
        gen_tick = 1'b0;
    endtask

    // k0 = falling edges already elapsed since the start request was driven.
    task automatic wait_done(input string name, input int k0);
        int k = k0;
        while (!done && k < 60) begin
            @(negedge clk_in);
            k++;
        end
        check(name, done ? k : -1, H + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        idle(2);

        // Blinker: horizontal -> vertical -> horizontal
        load(7, 16'h01C0);
        exp_gen++;
        push_done(exp_gen, 3, "t1_gen1");
        pulse_step();
        check("t1_busy", 32'(busy), 1);
        wait_done("t1_latency", 1);
        idle(1);
        for (int r = 0; r < H; r++) begin
            read_row(1'b0, r, (r >= 6 && r <= 8) ? 16'h0080 : 16'h0000, "t1_vert");
        end
        check("t1_gen_count", 32'(gen_count), 1);
        exp_gen++;
        push_done(exp_gen, 3, "t1_gen2");
        pulse_step();
        wait_done("t1_latency2", 1);
        idle(1);
        read_row(1'b0, 6, 16'h0000, "t1_horiz");
        read_row(1'b0, 7, 16'h01C0, "t1_horiz");
        read_row(1'b0, 8, 16'h0000, "t1_horiz");

        // Busy collisions: step and load while computing row 5
        exp_gen++;
        push_done(exp_gen, 3, "t4_gen");
        pulse_step();
        idle(5);
        step      = 1'b1;
        load_en   = 1'b1;
        load_row  = 4'd3;
        load_data = 16'hFFFF;
        @(negedge clk_in);
        step    = 1'b0;
        load_en = 1'b0;
        check("t4_overrun_set", 32'(overrun), 1);
        check("t4_busy_mid", 32'(busy), 1);
        wait_done("t4_latency", 7);
        idle(25);
        check("t4_overrun_sticky", 32'(overrun), 1);
        read_row(1'b0, 3, 16'h0000, "t4_load_ignored");
        read_row(1'b0, 7, 16'h0080, "t4_result");
        do_clear();
        check("t4_overrun_cleared", 32'(overrun), 0);
        read_row(1'b0, 7, 16'h0000, "t4_cleared");
        read_row(1'b0, 6, 16'h0000, "t4_cleared");

        // Boundary: blinker on row 0, loaded in the same cycle as the start
        exp_gen++;
        push_done(exp_gen, 3, "t3_gen");
        load_en   = 1'b1;
        load_row  = 4'd0;
        load_data = 16'h0007;
        step      = 1'b1;
        @(negedge clk_in);
        load_en = 1'b0;
        step    = 1'b0;
        wait_done("t3_latency", 1);
        idle(1);
        read_row(1'b0, 0, 16'h0002, "t3");
        read_row(1'b0, 1, 16'h0002, "t3");
        read_row(1'b0, 15, 16'h0002, "t3");
        read_row(1'b1, 0, 16'h0002, "t3");
        read_row(1'b1, 1, 16'h0002, "t3");
        read_row(1'b1, 15, 16'h0000, "t3");
        read_row(1'b1, 2, 16'h0000, "t3");

        // Toroidal glider: 4*W free-running generations return it home
        do_clear();
        load(0, 16'h0007);
        load(1, 16'h0001);
        load(2, 16'h0002);
        run = 1'b1;
        for (int g = 0; g < 4 * W; g++) begin
            exp_gen++;
            push_done(exp_gen, 5, "t2_glider");
            pulse_tick();
            wait_done("t2_latency", 1);
            idle(2);
        end
        run = 1'b0;
        for (int r = 0; r < H; r++) begin
            read_row(1'b0, r, (r == 0) ? 16'h0007 : (r == 1) ? 16'h0001 :
                     (r == 2) ? 16'h0002 : 16'h0000, "t2_home");
        end
        check("t2_overrun", 32'(overrun), 0);

        // Extinction of a single cell
        do_clear();
        load(5, 16'h0010);
        run = 1'b1;
        exp_gen++;
        push_done(exp_gen, 0, "t6_gen1");
        pulse_tick();
        wait_done("t6_latency", 1);
        idle(1);
        read_row(1'b0, 5, 16'h0000, "t6_died");
`ifdef LIFE_POPCOUNT_EN
        check("t6_extinct", 32'(extinct), 1);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            idle(20);
        end
        check("t6_ticks_ignored", 32'(gen_count), exp_gen);
        check("t6_no_overrun", 32'(overrun), 0);
        exp_gen++;
        push_done(exp_gen, 0, "t6_step");
        pulse_step();
        wait_done("t6_step_latency", 1);
`else
        exp_gen++;
        push_done(exp_gen, 0, "t6_gen2");
        pulse_tick();
        wait_done("t6_latency2", 1);
`endif
        run = 1'b0;
        idle(2);
        check("t6_gen_count", 32'(gen_count), exp_gen);

        // Reset while computing row 8
        do_clear();
        load(7, 16'h01C0);
        pulse_step();
        idle(8);
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_gen_count", 32'(gen_count), 0);
        idle(2);
        rst_n = 1'b1;
        idle(25);
        check("t5_gen_count_after", 32'(gen_count), 0);
        read_row(1'b0, 6, 16'h0000, "t5_grid");
        read_row(1'b0, 7, 16'h0000, "t5_grid");
        read_row(1'b0, 8, 16'h0000, "t5_grid");
        idle(3);

        check("done_q_drained", done_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
